// File: rtl/xor_mem_pkg.sv
// Shared widths and types for the XOR-encoded 4-read / 2-write memory.
package xor_mem_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned DEPTH      = 1 << ADDR_W;
    // Four user read ports plus one cross-read used to encode the other port's write.
    localparam int unsigned N_RD_PORTS = 5;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/xor_bank.sv
// Single-write, multi-read flop bank with asynchronous reads and async active-low clear.
module xor_bank
    import xor_mem_pkg::*;
#(
    parameter int unsigned BANK_DATA_W = xor_mem_pkg::DATA_W,
    parameter int unsigned BANK_ADDR_W = xor_mem_pkg::ADDR_W,
    parameter int unsigned BANK_DEPTH  = xor_mem_pkg::DEPTH,
    parameter int unsigned N_RD        = N_RD_PORTS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we,
    input  logic [BANK_ADDR_W-1:0]              wa,
    input  logic [BANK_DATA_W-1:0]              wd,
    input  logic [N_RD-1:0][BANK_ADDR_W-1:0]    ra,
    output logic [N_RD-1:0][BANK_DATA_W-1:0]    rd
);

    logic [BANK_DATA_W-1:0] mem [BANK_DEPTH];

    // Storage: clear every word on reset, otherwise one write per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BANK_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    for (genvar k = 0; k < int'(N_RD); k++) begin : g_rd
        assign rd[k] = mem[ra[k]];
    end

endmodule

// File: rtl/xor_memory_4r2w.sv
// 1024x8 RAM with two write and four read ports; logical word = B1[a] ^ B2[a].
module xor_memory_4r2w
    import xor_mem_pkg::*;
#(
    parameter int unsigned DATA_W = xor_mem_pkg::DATA_W,
    parameter int unsigned ADDR_W = xor_mem_pkg::ADDR_W,
    parameter int unsigned DEPTH  = xor_mem_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        enW,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    input  logic [ADDR_W-1:0] ra4,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] w1,
    input  logic [DATA_W-1:0] w2
);

    localparam int unsigned XRD = N_RD_PORTS - 1;

    logic [N_RD_PORTS-1:0][ADDR_W-1:0] b1_ra;
    logic [N_RD_PORTS-1:0][ADDR_W-1:0] b2_ra;
    logic [N_RD_PORTS-1:0][DATA_W-1:0] b1_rd;
    logic [N_RD_PORTS-1:0][DATA_W-1:0] b2_rd;
    logic                              collision_c;
    logic                              we1_c;
    logic                              we2_c;
    logic [DATA_W-1:0]                 wd1_c;
    logic [DATA_W-1:0]                 wd2_c;
    logic [1:0]                        unused_en;

    assign unused_en = enW[3:2];

    // Each bank's extra read port looks up the other write port's address.
    assign b1_ra = {wa2, ra4, ra3, ra2, ra1};
    assign b2_ra = {wa1, ra4, ra3, ra2, ra1};

    // Same-address dual write: port 2 alone encodes against B1, so content becomes w2.
    assign collision_c = enW[0] & enW[1] & (wa1 == wa2);
    assign we1_c       = enW[0] & ~collision_c;
    assign we2_c       = enW[1];

    assign wd1_c = w1 ^ b2_rd[XRD];
    assign wd2_c = w2 ^ b1_rd[XRD];

    xor_bank #(
        .BANK_DATA_W (DATA_W),
        .BANK_ADDR_W (ADDR_W),
        .BANK_DEPTH  (DEPTH),
        .N_RD        (N_RD_PORTS)
    ) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we1_c),
        .wa    (wa1),
        .wd    (wd1_c),
        .ra    (b1_ra),
        .rd    (b1_rd)
    );

    xor_bank #(
        .BANK_DATA_W (DATA_W),
        .BANK_ADDR_W (ADDR_W),
        .BANK_DEPTH  (DEPTH),
        .N_RD        (N_RD_PORTS)
    ) u_bank2 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we2_c),
        .wa    (wa2),
        .wd    (wd2_c),
        .ra    (b2_ra),
        .rd    (b2_rd)
    );

    assign r1 = b1_rd[0] ^ b2_rd[0];
    assign r2 = b1_rd[1] ^ b2_rd[1];
    assign r3 = b1_rd[2] ^ b2_rd[2];
    assign r4 = b1_rd[3] ^ b2_rd[3];

endmodule

// File: tb/tb_xor_memory_4r2w.sv
// Scoreboard bench for xor_memory_4r2w against a plain 2-write/4-read memory model.
module tb_xor_memory_4r2w;

    logic       clk;
    logic       rst_n;
    logic [3:0] enW;
    logic [9:0] ra1, ra2, ra3, ra4, wa1, wa2;
    logic [7:0] r1, r2, r3, r4, w1, w2;

    logic [7:0] model [1024];
    logic [7:0] exp_q [$];
    logic [9:0] adr_q [$];
    int         n_tests;
    int         n_failed;

    xor_memory_4r2w dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enW   (enW),
        .ra1   (ra1),
        .ra2   (ra2),
        .ra3   (ra3),
        .ra4   (ra4),
        .r1    (r1),
        .r2    (r2),
        .r3    (r3),
        .r4    (r4),
        .wa1   (wa1),
        .wa2   (wa2),
        .w1    (w1),
        .w2    (w2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] port_val(input int k);
        case (k)
            0:       return r1;
            1:       return r2;
            2:       return r3;
            default: return r4;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    endtask

    // Reference behaviour of one write edge: port 2 wins a same-address collision.
    task automatic apply_model(input logic [3:0] en, input logic [9:0] a1, input logic [7:0] d1,
                               input logic [9:0] a2, input logic [7:0] d2);
        if (en[0] && !(en[1] && a1 == a2)) model[a1] = d1;
        if (en[1]) model[a2] = d2;
    endtask

    // Drive read addresses and push the model's expected data.
    task automatic drive_reads(input logic [9:0] a1, input logic [9:0] a2,
                               input logic [9:0] a3, input logic [9:0] a4);
        ra1 = a1; ra2 = a2; ra3 = a3; ra4 = a4;
        exp_q.push_back(model[a1]); adr_q.push_back(a1);
        exp_q.push_back(model[a2]); adr_q.push_back(a2);
        exp_q.push_back(model[a3]); adr_q.push_back(a3);
        exp_q.push_back(model[a4]); adr_q.push_back(a4);
    endtask

    task automatic do_write(input logic [3:0] en, input logic [9:0] a1, input logic [7:0] d1,
                            input logic [9:0] a2, input logic [7:0] d2);
        enW = en; wa1 = a1; w1 = d1; wa2 = a2; w2 = d2;
        @(posedge clk);
        apply_model(en, a1, d1, a2, d2);
        #1;
        enW = 4'b0000;
    endtask

    task automatic test_reset();
        logic [7:0] e, g;
        logic [9:0] a;
        rst_n = 1'b0;
        enW = 4'b0011; wa1 = 10'd10; w1 = 8'hAA; wa2 = 10'd20; w2 = 8'hBB;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        enW = 4'b0000;
        drive_reads(10'd0, 10'd10, 10'd1023, 10'd20);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL reset port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    task automatic test_dual_write();
        logic [7:0] e, g;
        logic [9:0] a;
        do_write(4'b0011, 10'd10, 8'd10, 10'd20, 8'd20);
        do_write(4'b0011, 10'd30, 8'd30, 10'd40, 8'd40);
        drive_reads(10'd10, 10'd20, 10'd30, 10'd40);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e || g !== 8'((k + 1) * 10)) begin
                n_failed++;
                $display("FAIL dual_write port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    task automatic test_cross_overwrite();
        logic [7:0] e, g;
        logic [9:0] a;
        do_write(4'b0010, 10'd0, 8'h00, 10'd5, 8'h55);
        do_write(4'b0001, 10'd5, 8'hA3, 10'd0, 8'h00);
        drive_reads(10'd5, 10'd5, 10'd5, 10'd5);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e || g !== 8'hA3) begin
                n_failed++;
                $display("FAIL cross_overwrite port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    task automatic test_collision();
        logic [7:0] e, g;
        logic [9:0] a;
        do_write(4'b0001, 10'd7, 8'h3C, 10'd0, 8'h00);
        do_write(4'b0011, 10'd7, 8'h11, 10'd7, 8'h22);
        drive_reads(10'd7, 10'd7, 10'd5, 10'd10);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL collision port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] e, g;
        logic [9:0] a;
        do_write(4'b1100, 10'd10, 8'hEE, 10'd20, 8'hDD);
        drive_reads(10'd10, 10'd20, 10'd30, 10'd40);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL gating_reserved port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
        do_write(4'b0001, 10'd10, 8'h99, 10'd20, 8'h88);
        drive_reads(10'd10, 10'd20, 10'd30, 10'd1023);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL gating_port1 port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e, g;
        logic [9:0] a;
        do_write(4'b0011, 10'd10, 8'h12, 10'd20, 8'h34);
        drive_reads(10'd10, 10'd20, 10'd10, 10'd20);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL pre_reset port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
        // Pulse reset between edges: outputs must clear with no clock edge.
        #1;
        rst_n = 1'b0;
        clear_model();
        drive_reads(10'd10, 10'd20, 10'd10, 10'd20);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL async_clear port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
        #1;
        rst_n = 1'b1;
        do_write(4'b0001, 10'd10, 8'h7F, 10'd0, 8'h00);
        drive_reads(10'd10, 10'd20, 10'd0, 10'd1023);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL post_reset port%0d addr %0d: got %h expected %h", k + 1, a, g, e);
            end
        end
    endtask

    // Random traffic on a small address window; reads checked before and after each edge.
    task automatic test_back_to_back();
        logic [7:0] e, g;
        logic [9:0] a, x1, x2, x3;
        logic [3:0] en;
        logic [9:0] a1, a2;
        logic [7:0] d1, d2;
        for (int it = 0; it < 150; it++) begin
            en = 4'($urandom_range(0, 15));
            a1 = (it % 17 == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
            a2 = (it % 13 == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
            d1 = 8'($urandom); d2 = 8'($urandom);
            x1 = 10'($urandom_range(0, 15));
            x2 = 10'($urandom_range(0, 15));
            x3 = (it % 11 == 0) ? 10'd0 : 10'd1023;
            enW = en; wa1 = a1; w1 = d1; wa2 = a2; w2 = d2;
            drive_reads(a1, a2, x1, x3);
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
                n_tests++;
                if (g !== e) begin
                    n_failed++;
                    $display("FAIL b2b_pre it%0d port%0d addr %0d: got %h expected %h", it, k + 1, a, g, e);
                end
            end
            @(posedge clk);
            apply_model(en, a1, d1, a2, d2);
            #1;
            drive_reads(a1, a2, x2, x3);
            #1;
            for (int k = 0; k < 4; k++) begin
                e = exp_q.pop_front(); a = adr_q.pop_front(); g = port_val(k);
                n_tests++;
                if (g !== e) begin
                    n_failed++;
                    $display("FAIL b2b_post it%0d port%0d addr %0d: got %h expected %h", it, k + 1, a, g, e);
                end
            end
        end
        enW = 4'b0000;
    endtask

    initial begin
        n_tests = 0;
        n_failed = 0;
        rst_n = 1'b0;
        enW = 4'b0000;
        ra1 = '0; ra2 = '0; ra3 = '0; ra4 = '0;
        wa1 = '0; wa2 = '0; w1 = '0; w2 = '0;
        test_reset();
        test_dual_write();
        test_cross_overwrite();
        test_collision();
        test_enable_gating();
        test_async_reset();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_tests++;
            n_failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

// File: doc/xor_memory_4r2w.md
# xor_memory_4r2w

XOR-based multiported RAM (1024 × 8) with two independent write ports and four independent read ports, built from single-write banks whose contents are XOR-combined on read. It is the shared register/buffer storage for datapaths that need 2 writes and 4 reads per cycle without banking conflicts. Writes are synchronous. Reads are asynchronous (combinational).

## Interface
- `DATA_W`, default 8: data width.
- `ADDR_W`, default 10: address width.
- `DEPTH`, default 1024 (2^ADDR_W): number of words.

Ports:
- `clk`  in  1  single clock; all writes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; clears all storage.
- `enW`  in  4  write enables. Bit0 = port 1, bit1 = port 2. Bits [3:2] reserved, ignored.
- `ra1`..`ra4`  in  ADDR_W  read addresses, ports 1–4.
- `r1`..`r4`  out  DATA_W  read data, ports 1–4.
- `wa1`, `wa2`  in  ADDR_W  write addresses, ports 1–2.
- `w1`, `w2`  in  DATA_W  write data, ports 1–2.

## Operation
- Two banks, B1 (owned by write port 1) and B2 (owned by write port 2), each DEPTH × DATA_W, flop-based.
- Logical content of address a is B1[a] ^ B2[a].
- Write port 1 (enW[0]=1) stores `w1 ^ B2[wa1]` into B1[wa1].
- Write port 2 (enW[1]=1) stores `w2 ^ B1[wa2]` into B2[wa2].
- The cross-bank terms are the pre-edge contents.
- Read port k: `rk = B1[rak] ^ B2[rak]`, purely combinational, for k = 1..4.
- Write-write collision (both enabled, wa1 == wa2): port 2 wins.
  - Port 1's write is suppressed that cycle.
  - Logical content after the edge = w2.
- Any read address may equal any other read or write address; there are no read restrictions.
- Reset: all words of B1 and B2 are cleared to 0, so every address reads 0.

## Timing
- Write latency: new data is visible on any read port combinationally right after the rising edge that samples the write.
- Read during write to the same address returns the old value until the edge, then the new value. There is no write-through bypass.
- rst_n assertion clears storage immediately, independent of clk. Outputs go to 0 within the combinational read delay.
- Writes are ignored while rst_n = 0.
- On the first edge after deassertion, writes proceed normally.
- Reset asserted mid-sequence discards all prior writes.
- Addresses are full-range. There is no wrap or out-of-range case when DEPTH = 2^ADDR_W.

## Structure
- Shared package `xor_mem_pkg`: `DATA_W`, `ADDR_W`, `DEPTH` defaults, and typedefs `addr_t` and `data_t`.
- One sub-module `xor_bank`: DEPTH × DATA_W storage with 1 synchronous write port, N asynchronous read ports (N = 5: four user reads plus one cross-read), and async active-low clear.
- Top level instantiates two `xor_bank` instances and adds:
  - the write-data XOR encoding;
  - the collision suppression for port 1;
  - four output XORs.

## Test plan
- **Reset:** assert rst_n = 0, release, read addresses 0, 10, 1023 → all 0.
- **Dual write, quad read:**
  - Write (10 → 10) on port 1 and (20 → 20) on port 2 in cycle 1.
  - Write (30 → 30) on port 1 and (40 → 40) on port 2 in cycle 2.
  - Set ra1..ra4 = 10, 20, 30, 40 → r1..r4 = 10, 20, 30, 40.
- **Cross-bank overwrite:**
  - Port 2 writes 0x55 to address 5.
  - Next cycle, port 1 writes 0xA3 to address 5.
  - All four read ports at address 5 → 0xA3.
- **Collision:** enW = 2'b11, wa1 = wa2 = 7, w1 = 0x11, w2 = 0x22 → address 7 reads 0x22.
- **Enable gating:** enW = 4'b1100 with any wa/w → no address changes. enW = 4'b0001 → only port 1 writes.
- **Async reset mid-sequence:**
  - After writes to 10/20, pulse rst_n low between clock edges → r outputs drop to 0 without a clock edge.
  - Subsequent write to 10 with value 0x7F reads back 0x7F.
